// File: rtl/keypad_entry.sv
// Keypad scanner: column sweep, sweep classification, press/release debounce,
// and four-digit operand assembly with a valid/ack handoff.
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clear,
  input  logic        word_ack,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic [2:0]  digit_count,
  output logic        key_strobe,
  output logic [3:0]  key_code
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS_DB, ST_HELD, ST_RELEASE_DB} state_t;
  typedef enum logic [1:0] {SW_NONE, SW_KEY, SW_MULTI} sweep_t;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx;
  logic [1:0]       next_idx_c;
  logic             slot_end_c;

  logic [3:0]       low_c;
  logic [2:0]       pop_c;
  logic [1:0]       row_sel_c;
  logic [2:0]       acc_raw_c;
  logic [1:0]       acc_sat_c;
  logic [3:0]       acc_code_nxt_c;

  logic [1:0]       acc_cnt;
  logic [3:0]       acc_code;
  logic             sweep_done;
  sweep_t           sweep_kind;
  logic [3:0]       sweep_code;

  state_t           state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d, db_inc_c;
  logic [3:0]       code_q, code_d;
  logic             accept_c;

  assign slot_end_c = (div_q == DIV_W'(SCAN_DIV - 1));
  assign next_idx_c = col_idx + 2'd1;

  // Column divider and one-hot-low column drive
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      col_idx <= 2'd0;
      col_out <= 4'b1110;
    end else if (slot_end_c) begin
      div_q   <= '0;
      col_idx <= next_idx_c;
      col_out <= ~(4'b0001 << next_idx_c);
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  // Low-row count and row index for the column currently driven
  always_comb begin
    low_c     = ~row_in;
    pop_c     = 3'(low_c[0]) + 3'(low_c[1]) + 3'(low_c[2]) + 3'(low_c[3]);
    row_sel_c = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (low_c[r]) row_sel_c = 2'(r);
    end
    acc_raw_c      = 3'(acc_cnt) + pop_c;
    acc_sat_c      = (acc_raw_c >= 3'd2) ? 2'd2 : acc_raw_c[1:0];
    acc_code_nxt_c = acc_code;
    if (acc_cnt == 2'd0 && pop_c == 3'd1) acc_code_nxt_c = {row_sel_c, col_idx};
  end

  // Accumulate low rows over a sweep; publish the classification after column 3
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      sweep_done <= 1'b0;
      sweep_kind <= SW_NONE;
      sweep_code <= 4'd0;
    end else begin
      sweep_done <= 1'b0;
      if (slot_end_c) begin
        if (col_idx == 2'd3) begin
          sweep_done <= 1'b1;
          sweep_kind <= (acc_sat_c == 2'd0) ? SW_NONE :
                        (acc_sat_c == 2'd1) ? SW_KEY : SW_MULTI;
          sweep_code <= acc_code_nxt_c;
          acc_cnt    <= 2'd0;
          acc_code   <= 4'd0;
        end else begin
          acc_cnt    <= acc_sat_c;
          acc_code   <= acc_code_nxt_c;
        end
      end
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      db_cnt_q <= '0;
      code_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      code_q   <= code_d;
    end
  end

  assign db_inc_c = db_cnt_q + DB_W'(1);

  // Debounce FSM next state; a press is accepted once, on entry to HELD
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    code_d   = code_q;
    accept_c = 1'b0;
    if (sweep_done) begin
      case (state_q)
        ST_IDLE: begin
          if (sweep_kind == SW_KEY) begin
            code_d   = sweep_code;
            db_cnt_d = DB_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept_c = 1'b1;
              state_d  = ST_HELD;
            end else begin
              state_d  = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (sweep_kind == SW_KEY && sweep_code == code_q) begin
            db_cnt_d = db_inc_c;
            if (db_inc_c == DB_W'(DEBOUNCE_SCANS)) begin
              accept_c = 1'b1;
              state_d  = ST_HELD;
            end
          end else if (sweep_kind == SW_KEY) begin
            code_d   = sweep_code;
            db_cnt_d = DB_W'(1);
          end else begin
            db_cnt_d = '0;
            state_d  = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (sweep_kind == SW_NONE) begin
            db_cnt_d = DB_W'(1);
            state_d  = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (sweep_kind == SW_NONE) begin
            db_cnt_d = db_inc_c;
            if (db_inc_c == DB_W'(DEBOUNCE_SCANS)) begin
              db_cnt_d = '0;
              state_d  = ST_IDLE;
            end
          end else begin
            db_cnt_d = '0;
            state_d  = ST_HELD;
          end
        end
        default: begin
          db_cnt_d = '0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // Word assembly: clear beats ack beats press; presses while valid are dropped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_out    <= 16'd0;
      word_valid  <= 1'b0;
      digit_count <= 3'd0;
      key_strobe  <= 1'b0;
      key_code    <= 4'd0;
    end else begin
      key_strobe <= 1'b0;
      if (clear || (word_ack && word_valid)) begin
        word_out    <= 16'd0;
        digit_count <= 3'd0;
        word_valid  <= 1'b0;
      end else if (accept_c && !word_valid) begin
        key_strobe  <= 1'b1;
        key_code    <= sweep_code;
        word_out    <= {word_out[11:0], sweep_code};
        digit_count <= digit_count + 3'd1;
        word_valid  <= (digit_count == 3'd3);
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 key matrix.
module tb_keypad_entry;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        clear;
  logic        word_ack;
  logic [15:0] word_out;
  logic        word_valid;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic [3:0]  key_code;

  logic [15:0] pressed = 16'd0;
  int unsigned strobe_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned s0;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
    .clear(clear), .word_ack(word_ack), .word_out(word_out),
    .word_valid(word_valid), .digit_count(digit_count),
    .key_strobe(key_strobe), .key_code(key_code)
  );

  always #5 clock = ~clock;

  // Key matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clock) if (key_strobe) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Return at the negedge of the first cycle of a new column-0 slot
  task automatic wait_col0();
    logic [3:0] prev;
    bit found = 0;
    prev = col_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (col_out == 4'b1110 && prev == 4'b0111) found = 1;
      prev = col_out;
    end
    if (!found) check("col0_timeout", 32'(0), 32'(1));
  endtask

  task automatic press_key(input logic [15:0] mask, input int sweeps);
    wait_col0();
    pressed = mask;
    repeat (sweeps) wait_col0();
    pressed = 16'd0;
    repeat (3) wait_col0();
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input logic [2:0] n, input logic v);
    check({tag, "_word"},  32'(word_out),    32'(w));
    check({tag, "_count"}, 32'(digit_count), 32'(n));
    check({tag, "_valid"}, 32'(word_valid),  32'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; word_ack = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_col", 32'(col_out), 32'h0000_000E);
    check_word("rst", 16'h0000, 3'd0, 1'b0);
    check("rst_strobe", 32'(key_strobe), 32'(0));
    check("rst_code", 32'(key_code), 32'(0));
    @(negedge clock); reset = 1'b1;

    // Single press: strobe on the edge after the second matching sweep
    s0 = strobe_cnt;
    wait_col0();
    pressed = 16'(1) << 5;
    wait_col0();
    wait_col0();
    check("strobe_early", 32'(key_strobe), 32'(0));
    @(negedge clock);
    check("strobe_edge", 32'(key_strobe), 32'(1));
    check("single_code", 32'(key_code), 32'h5);
    wait_col0();
    pressed = 16'd0;
    repeat (3) wait_col0();
    check("single_strobes", strobe_cnt - s0, 32'(1));
    check_word("single", 16'h0005, 3'd1, 1'b0);

    pulse_clear();
    check_word("clear", 16'h0000, 3'd0, 1'b0);
    check("clear_keeps_code", 32'(key_code), 32'h5);

    // Full word 1,2,3,4
    s0 = strobe_cnt;
    press_key(16'(1) << 1, 3);
    press_key(16'(1) << 2, 3);
    press_key(16'(1) << 3, 3);
    press_key(16'(1) << 4, 3);
    check("full_strobes", strobe_cnt - s0, 32'(4));
    check_word("full", 16'h1234, 3'd4, 1'b1);
    check("full_code", 32'(key_code), 32'h4);
    repeat (50) @(negedge clock);
    check_word("full_hold", 16'h1234, 3'd4, 1'b1);
    word_ack = 1'b1;
    @(negedge clock); word_ack = 1'b0;
    check_word("ack", 16'h0000, 3'd0, 1'b0);

    // Bounce then long hold of key 9
    s0 = strobe_cnt;
    press_key(16'(1) << 9, 1);
    check("bounce_strobes", strobe_cnt - s0, 32'(0));
    press_key(16'(1) << 9, 20);
    check("hold_strobes", strobe_cnt - s0, 32'(1));
    check_word("hold", 16'h0009, 3'd1, 1'b0);

    // Two keys in one column is rejected
    pulse_clear();
    s0 = strobe_cnt;
    press_key((16'(1) << 3) | (16'(1) << 7), 5);
    check("multi_strobes", strobe_cnt - s0, 32'(0));
    check_word("multi", 16'h0000, 3'd0, 1'b0);

    // Press while valid is consumed silently
    press_key(16'(1) << 10, 3);
    press_key(16'(1) << 11, 3);
    press_key(16'(1) << 12, 3);
    press_key(16'(1) << 13, 3);
    check_word("abcd", 16'hABCD, 3'd4, 1'b1);
    s0 = strobe_cnt;
    press_key(16'(1) << 5, 3);
    check("valid_press_strobes", strobe_cnt - s0, 32'(0));
    check_word("valid_press", 16'hABCD, 3'd4, 1'b1);
    check("valid_press_code", 32'(key_code), 32'hD);
    @(negedge clock); word_ack = 1'b1;
    @(negedge clock); word_ack = 1'b0;
    check_word("ack2", 16'h0000, 3'd0, 1'b0);

    // Clear on the accept edge of the fourth digit drops it
    press_key(16'(1) << 1, 3);
    press_key(16'(1) << 2, 3);
    press_key(16'(1) << 3, 3);
    check_word("three", 16'h0123, 3'd3, 1'b0);
    s0 = strobe_cnt;
    wait_col0();
    pressed = 16'(1) << 6;
    wait_col0();
    wait_col0();
    clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    check("clr_accept_strobe", 32'(key_strobe), 32'(0));
    check_word("clr_accept", 16'h0000, 3'd0, 1'b0);
    wait_col0();
    pressed = 16'd0;
    repeat (3) wait_col0();
    check("clr_accept_strobes", strobe_cnt - s0, 32'(0));

    // Clear and ack together while valid
    press_key(16'(1) << 8, 3);
    press_key(16'(1) << 7, 3);
    press_key(16'(1) << 6, 3);
    press_key(16'(1) << 5, 3);
    check_word("w8765", 16'h8765, 3'd4, 1'b1);
    @(negedge clock); clear = 1'b1; word_ack = 1'b1;
    @(negedge clock); clear = 1'b0; word_ack = 1'b0;
    check_word("clr_ack", 16'h0000, 3'd0, 1'b0);

    // Ack while not valid is ignored; then async reset mid-sweep
    press_key(16'(1) << 14, 3);
    press_key(16'(1) << 15, 3);
    check_word("ef", 16'h00EF, 3'd2, 1'b0);
    @(negedge clock); word_ack = 1'b1;
    @(negedge clock); word_ack = 1'b0;
    check_word("ack_idle", 16'h00EF, 3'd2, 1'b0);
    repeat (6) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_word("async_rst", 16'h0000, 3'd0, 1'b0);
    check("async_rst_col", 32'(col_out), 32'hE);
    check("async_rst_code", 32'(key_code), 32'(0));
    check("async_rst_strobe", 32'(key_strobe), 32'(0));
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    check("step_c0", 32'(col_out), 32'hE);
    @(negedge clock);
    check("step_c1", 32'(col_out), 32'hD);
    repeat (4) @(negedge clock);
    check("step_c2", 32'(col_out), 32'hB);
    repeat (4) @(negedge clock);
    check("step_c3", 32'(col_out), 32'h7);
    repeat (4) @(negedge clock);
    check("step_wrap", 32'(col_out), 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
